// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word-addressed load/store at a time, inserts
// WAIT_CYCLES wait states, accesses the internal SRAM and returns a response.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    // state  | meaning
    // S_IDLE | ready for a request; latches it on accept
    // S_WAIT | counting wait states; access happens on the edge leaving this state
    // S_RESP | response held until the requester takes it
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [2**ADDR_WIDTH];

    logic                  access;
    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic                  acc_fault;
    logic [ADDR_WIDTH-1:0] acc_idx;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        access       = 1'b0;
        acc_we       = we_q;
        acc_addr     = addr_q;
        acc_wdata    = wdata_q;
        acc_be       = be_q;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: access straight from the request inputs.
                        state_d   = S_RESP;
                        access    = 1'b1;
                        acc_we    = req_we_i;
                        acc_addr  = req_addr_i;
                        acc_wdata = req_wdata_i;
                        acc_be    = req_be_i;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        acc_fault = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
        acc_idx   = acc_addr[ADDR_WIDTH+1:2];

        if (access) begin
            rdata_d = (acc_we || acc_fault) ? 32'd0 : mem_q[acc_idx];
            err_d   = acc_fault;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; a reset on the commit edge suppresses the store.
    always_ff @(posedge clk_i) begin
        if (access && acc_we && !acc_fault && !reset_i) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default instance (WAIT_CYCLES=2) plus a
// zero-wait instance for the back-to-back case.
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        r1_valid, r1_ready, r1_we;
    logic [31:0] r1_addr, r1_wdata;
    logic [3:0]  r1_be;
    logic        r1_resp_valid, r1_resp_ready, r1_resp_err;
    logic [31:0] r1_resp_rdata;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(r1_valid), .req_ready_o(r1_ready), .req_we_i(r1_we),
        .req_addr_i(r1_addr), .req_wdata_i(r1_wdata), .req_be_i(r1_be),
        .resp_valid_o(r1_resp_valid), .resp_ready_i(r1_resp_ready),
        .resp_rdata_o(r1_resp_rdata), .resp_err_o(r1_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request, return cycles from accept to resp_valid (accept cycle = 1).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic complete();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        issue(we, addr, wdata, be, lat);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        complete();
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        reset = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; resp_ready = 0;
        r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_be = 0; r1_resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);

        // Full-word store then load
        do_req("st_beef", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
        do_req("ld_beef", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Byte-masked store
        do_req("st_byte", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'd0, 1'b0);
        do_req("ld_byte", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);

        // Faults: misaligned and out of range, no aliasing onto index 0
        do_req("st_zero", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'd0, 1'b0);
        do_req("ld_mis", 1'b0, 32'h12, 32'd0, 4'h0, 32'd0, 1'b1);
        do_req("ld_oor", 1'b0, 32'h1000, 32'd0, 4'h0, 32'd0, 1'b1);
        do_req("st_oor", 1'b1, 32'h1000, 32'h55555555, 4'hF, 32'd0, 1'b1);
        do_req("st_mis", 1'b1, 32'h11, 32'h66666666, 4'hF, 32'd0, 1'b1);
        do_req("ld_zero", 1'b0, 32'h0, 32'd0, 4'h0, 32'h0BADF00D, 1'b0);
        do_req("ld_after_mis", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);

        // Highest valid index
        do_req("st_top", 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
        do_req("ld_top", 1'b0, 32'hFFC, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0);

        // Store with no byte enables
        do_req("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
        do_req("ld_be0", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);

        // Backpressure in RESP
        issue(1'b0, 32'h10, 32'd0, 4'h0, lat);
        check("bp_lat", 32'(lat), 32'd3);
        held = 32'hDEADBEAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, held);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        complete();
        check("bp_valid_drop", {31'd0, resp_valid}, 32'd0);
        check("bp_idle_ready", {31'd0, req_ready}, 32'd1);

        // Reset during WAIT abandons the store
        do_req("st_20", 1'b1, 32'h20, 32'h11112222, 4'hF, 32'd0, 1'b0);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("wait_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstw_req_ready", {31'd0, req_ready}, 32'd1);
        check("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
        do_req("ld_20", 1'b0, 32'h20, 32'd0, 4'h0, 32'h11112222, 1'b0);

        // Reset during RESP keeps a committed store
        issue(1'b1, 32'h24, 32'h33334444, 4'hF, lat);
        check("rstr_lat", 32'(lat), 32'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstr_resp_valid", {31'd0, resp_valid}, 32'd0);
        do_req("ld_24", 1'b0, 32'h24, 32'd0, 4'h0, 32'h33334444, 1'b0);

        // Zero wait states: request held valid, one response every two cycles
        for (int i = 0; i < 4; i++) begin
            logic        we;
            logic [31:0] addr, wdata, exp;
            case (i)
                0: begin we = 1'b1; addr = 32'h40; wdata = 32'hA5A5A5A5; exp = 32'd0; end
                1: begin we = 1'b1; addr = 32'h44; wdata = 32'h5A5A5A5A; exp = 32'd0; end
                2: begin we = 1'b0; addr = 32'h40; wdata = 32'd0; exp = 32'hA5A5A5A5; end
                default: begin we = 1'b0; addr = 32'h44; wdata = 32'd0; exp = 32'h5A5A5A5A; end
            endcase
            check("w0_ready", {31'd0, r1_ready}, 32'd1);
            r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_be = 4'hF; r1_valid = 1'b1;
            @(posedge clk); #1;
            check("w0_valid", {31'd0, r1_resp_valid}, 32'd1);
            check("w0_rdata", r1_resp_rdata, exp);
            check("w0_busy", {31'd0, r1_ready}, 32'd0);
            @(posedge clk); #1;
            check("w0_drop", {31'd0, r1_resp_valid}, 32'd0);
        end
        r1_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
